// File: rtl/fft2d_pkg.sv
// Shared definitions for the 2D FFT pipeline: default geometry, sample field layout
// and the corner-turn state encoding.
package fft2d_pkg;

    localparam int unsigned N_DEF  = 128;
    localparam int unsigned DW_DEF = 32;

    // Complex sample: real part in the low half, imaginary part in the high half
    localparam int unsigned RE_LSB_DEF = 0;
    localparam int unsigned RE_MSB_DEF = DW_DEF / 2 - 1;
    localparam int unsigned IM_LSB_DEF = DW_DEF / 2;
    localparam int unsigned IM_MSB_DEF = DW_DEF - 1;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } ct_state_e;

endpackage

// File: rtl/corner_turn_ram.sv
// Simple dual-port frame store: one write port, one read port with a registered
// (1-cycle) read. Contents are intentionally not reset so it maps onto block RAM.
module corner_turn_ram #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 14
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/corner_turn_axis.sv
// Corner-turn buffer between the row FFT and the column FFT: captures one N x N frame
// row-major, then replays it column-major through a 2-entry skid stage.
module corner_turn_axis
    import fft2d_pkg::*;
#(
    parameter int unsigned N  = N_DEF,
    parameter int unsigned DW = DW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] s_axis_tdata,
    input  logic          s_axis_tvalid,
    output logic          s_axis_tready,
    input  logic          s_axis_tlast,
    output logic [DW-1:0] m_axis_tdata,
    output logic          m_axis_tvalid,
    input  logic          m_axis_tready,
    output logic          m_axis_tlast,
    output logic          frame_done,
    output logic          tlast_err,
    input  logic          tlast_err_clr
);

    localparam int unsigned LOG2N    = $clog2(N);
    localparam int unsigned AW       = 2 * LOG2N;
    localparam int unsigned LAST_IDX = N * N - 1;

    typedef struct packed {
        logic          eof;
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    ct_state_e     state_q, state_d;
    logic [AW-1:0] wr_cnt_q, wr_cnt_d;
    logic [AW-1:0] rd_cnt_q, rd_cnt_d;
    logic          rd_done_q, rd_done_d;
    logic          s_rdy_q, s_rdy_d;
    logic          pend_q, pend_d;
    logic          pend_last_q, pend_last_d;
    logic          pend_eof_q, pend_eof_d;
    beat_t         out_q, out_d;
    logic          out_vld_q, out_vld_d;
    beat_t         sp_q, sp_d;
    logic          sp_vld_q, sp_vld_d;
    logic          frame_done_q, frame_done_d;
    logic          err_q, err_d;

    logic          s_hs;
    logic          pop;
    logic          room;
    logic          issue;
    logic          exp_last;
    logic [1:0]    occ_next;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] ram_rdata;

    assign s_hs     = s_axis_tvalid & s_rdy_q;
    assign pop      = out_vld_q & m_axis_tready;
    assign exp_last = (wr_cnt_q[LOG2N-1:0] == {LOG2N{1'b1}});

    // Occupancy the skid stage will hold next cycle, before any read issued now lands
    assign occ_next = 2'(out_vld_q) + 2'(sp_vld_q) - 2'(pop) + 2'(pend_q);
    assign room     = (occ_next < 2'd2);
    assign issue    = (state_q == DRAIN) & ~rd_done_q & room;

    // Column-major index k maps to row-major address (k mod N)*N + k/N
    assign rd_addr  = {rd_cnt_q[LOG2N-1:0], rd_cnt_q[AW-1:LOG2N]};

    corner_turn_ram #(
        .DW(DW),
        .AW(AW)
    ) u_ram (
        .clk    (clk),
        .we_i   (s_hs),
        .waddr_i(wr_cnt_q),
        .wdata_i(s_axis_tdata),
        .raddr_i(rd_addr),
        .rdata_o(ram_rdata)
    );

    always_comb begin
        state_d      = state_q;
        wr_cnt_d     = wr_cnt_q;
        rd_cnt_d     = rd_cnt_q;
        rd_done_d    = rd_done_q;
        pend_d       = issue;
        pend_last_d  = (rd_cnt_q[LOG2N-1:0] == {LOG2N{1'b1}});
        pend_eof_d   = (rd_cnt_q == AW'(LAST_IDX));
        out_d        = out_q;
        out_vld_d    = out_vld_q;
        sp_d         = sp_q;
        sp_vld_d     = sp_vld_q;
        frame_done_d = 1'b0;
        // A fresh mismatch wins over a clear in the same cycle
        err_d        = (err_q & ~tlast_err_clr) | (s_hs & (s_axis_tlast != exp_last));

        unique case (state_q)
            FILL: begin
                if (s_hs) begin
                    wr_cnt_d = wr_cnt_q + AW'(1);
                    if (wr_cnt_q == AW'(LAST_IDX)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (issue) begin
                    rd_cnt_d = rd_cnt_q + AW'(1);
                    if (rd_cnt_q == AW'(LAST_IDX)) begin
                        rd_done_d = 1'b1;
                    end
                end
                if (pop && out_q.eof) begin
                    state_d      = FILL;
                    frame_done_d = 1'b1;
                    wr_cnt_d     = '0;
                    rd_cnt_d     = '0;
                    rd_done_d    = 1'b0;
                end
            end
            default: state_d = FILL;
        endcase

        // Skid stage: head is the output register, spare absorbs the in-flight read
        if (pop) begin
            out_d     = sp_q;
            out_vld_d = sp_vld_q;
            sp_vld_d  = 1'b0;
        end
        if (pend_q) begin
            if (!out_vld_d) begin
                out_d     = '{eof: pend_eof_q, last: pend_last_q, data: ram_rdata};
                out_vld_d = 1'b1;
            end else begin
                sp_d      = '{eof: pend_eof_q, last: pend_last_q, data: ram_rdata};
                sp_vld_d  = 1'b1;
            end
        end

        s_rdy_d = (state_d == FILL);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= FILL;
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
            rd_done_q    <= 1'b0;
            s_rdy_q      <= 1'b0;
            pend_q       <= 1'b0;
            pend_last_q  <= 1'b0;
            pend_eof_q   <= 1'b0;
            out_q        <= '0;
            out_vld_q    <= 1'b0;
            sp_q         <= '0;
            sp_vld_q     <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_cnt_q     <= wr_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            rd_done_q    <= rd_done_d;
            s_rdy_q      <= s_rdy_d;
            pend_q       <= pend_d;
            pend_last_q  <= pend_last_d;
            pend_eof_q   <= pend_eof_d;
            out_q        <= out_d;
            out_vld_q    <= out_vld_d;
            sp_q         <= sp_d;
            sp_vld_q     <= sp_vld_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

    assign s_axis_tready = s_rdy_q;
    assign m_axis_tdata  = out_q.data;
    assign m_axis_tlast  = out_q.last;
    assign m_axis_tvalid = out_vld_q;
    assign frame_done    = frame_done_q;
    assign tlast_err     = err_q;

endmodule

// File: tb/tb_corner_turn_axis.sv
// Bench for corner_turn_axis: an N=4 instance checked every cycle against a queue-based
// transpose model, plus an N=128 instance streamed through one full frame.
module tb_corner_turn_axis;
    import fft2d_pkg::*;

    localparam int unsigned NS  = 4;
    localparam int unsigned NN  = NS * NS;
    localparam int unsigned NB  = 128;
    localparam int unsigned NNB = NB * NB;

    logic        clk;
    logic        reset;
    logic [31:0] s_tdata;
    logic        s_tvalid, s_tready, s_tlast;
    logic [31:0] m_tdata;
    logic        m_tvalid, m_tready, m_tlast;
    logic        frame_done, tlast_err, tlast_err_clr;

    logic        b_reset;
    logic [31:0] b_s_tdata;
    logic        b_s_tvalid, b_s_tready, b_s_tlast;
    logic [31:0] b_m_tdata;
    logic        b_m_tvalid, b_m_tready, b_m_tlast;
    logic        b_frame_done, b_tlast_err, b_clr;

    corner_turn_axis #(.N(NS), .DW(32)) u_dut (
        .clk(clk), .reset(reset),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .s_axis_tlast(s_tlast),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .m_axis_tlast(m_tlast),
        .frame_done(frame_done), .tlast_err(tlast_err), .tlast_err_clr(tlast_err_clr)
    );

    corner_turn_axis #(.N(NB), .DW(32)) u_big (
        .clk(clk), .reset(b_reset),
        .s_axis_tdata(b_s_tdata), .s_axis_tvalid(b_s_tvalid), .s_axis_tready(b_s_tready),
        .s_axis_tlast(b_s_tlast),
        .m_axis_tdata(b_m_tdata), .m_axis_tvalid(b_m_tvalid), .m_axis_tready(b_m_tready),
        .m_axis_tlast(b_m_tlast),
        .frame_done(b_frame_done), .tlast_err(b_tlast_err), .tlast_err_clr(b_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    endtask

    // ---------------- behavioural model of the N=4 instance ----------------
    logic [31:0] frame [NN];
    logic [31:0] exp_q [$];
    bit          exp_last_q [$];
    logic [31:0] out_log [$];
    int          last_log [$];
    int          widx, popped, drain_cyc, fd_cnt, out_cnt;
    bit          in_drain, fd_exp, err_m, first_after, prev_stall, prev_last;
    logic [31:0] prev_data;
    int          rdy_pct;

    initial begin
        fd_cnt = 0; out_cnt = 0; widx = 0; popped = 0; drain_cyc = 0;
        in_drain = 0; fd_exp = 0; err_m = 0; first_after = 1; prev_stall = 0;
    end

    always @(negedge clk) begin
        if (reset) begin
            chk("rst_s_tready", s_tready, 0);
            chk("rst_m_tvalid", m_tvalid, 0);
            chk("rst_m_tlast", m_tlast, 0);
            chk("rst_m_tdata", m_tdata, 0);
            chk("rst_frame_done", frame_done, 0);
            chk("rst_tlast_err", tlast_err, 0);
            widx = 0; popped = 0; in_drain = 0; fd_exp = 0; err_m = 0;
            first_after = 1; prev_stall = 0;
            exp_q.delete(); exp_last_q.delete();
        end else begin
            chk("s_tready", s_tready, (!in_drain && !first_after) ? 1 : 0);
            first_after = 0;
            chk("tlast_err", tlast_err, err_m);
            chk("frame_done", frame_done, fd_exp);
            if (frame_done) fd_cnt++;
            fd_exp = 0;
            if (in_drain) begin
                drain_cyc++;
                if (drain_cyc <= 3) chk("first_valid_latency", m_tvalid, (drain_cyc == 3) ? 1 : 0);
            end
            if (prev_stall) begin
                chk("stall_valid", m_tvalid, 1);
                chk("stall_data", m_tdata, prev_data);
                chk("stall_last", m_tlast, prev_last);
            end
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
            prev_last  = m_tlast;
            if (m_tvalid && m_tready) begin
                chk("beat_expected", (exp_q.size() > 0) ? 1 : 0, 1);
                if (exp_q.size() > 0) begin
                    chk("out_data", m_tdata, exp_q.pop_front());
                    chk("out_last", m_tlast, exp_last_q.pop_front());
                end
                out_log.push_back(m_tdata);
                if (m_tlast) last_log.push_back(out_cnt);
                out_cnt++;
                popped++;
                if (popped % NN == 0) begin
                    fd_exp   = 1;
                    in_drain = 0;
                end
            end
            err_m = (err_m && !tlast_err_clr) ||
                    (s_tvalid && s_tready && (s_tlast != (widx % NS == NS - 1)));
            if (s_tvalid && s_tready) begin
                frame[widx] = s_tdata;
                widx++;
                if (widx == NN) begin
                    for (int k = 0; k < NN; k++) begin
                        exp_q.push_back(frame[(k % NS) * NS + k / NS]);
                        exp_last_q.push_back(k % NS == NS - 1);
                    end
                    widx      = 0;
                    in_drain  = 1;
                    drain_cyc = 0;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        m_tready = ($urandom_range(99) < rdy_pct);
    end

    task automatic send_beat(input logic [31:0] d, input bit last, input int vpct);
        int  budget;
        bit  done;
        budget = 0;
        done   = 0;
        s_tdata  = d;
        s_tlast  = last;
        s_tvalid = ($urandom_range(99) < vpct);
        while (!done) begin
            @(negedge clk);
            if (s_tvalid && s_tready) begin
                @(posedge clk); #1;
                s_tvalid = 0;
                done = 1;
            end else begin
                budget++;
                if (budget > 2000) begin
                    chk("send_timeout_tready", s_tready, 1);
                    s_tvalid = 0;
                    done = 1;
                end else begin
                    @(posedge clk); #1;
                    if (!s_tvalid) s_tvalid = ($urandom_range(99) < vpct);
                end
            end
        end
    endtask

    task automatic wait_frames(input int target);
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            if (fd_cnt >= target) break;
        end
        #1;
        chk("frames_done", fd_cnt, target);
    endtask

    int exp_order [NN];
    int base;
    int b_stall, b_mis, b_k, b_low, b_fd, b_tl;

    initial begin
        exp_order = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};
        reset = 1; s_tvalid = 0; s_tdata = 0; s_tlast = 0; tlast_err_clr = 0;
        rdy_pct = 100; m_tready = 1;
        b_reset = 1; b_s_tvalid = 0; b_s_tdata = 0; b_s_tlast = 0; b_m_tready = 1; b_clr = 0;
        repeat (3) @(posedge clk);
        #1 reset = 0;

        // Index data, full throughput
        for (int i = 0; i < NN; i++) send_beat(32'(i), (i % NS) == NS - 1, 100);
        wait_frames(1);
        for (int i = 0; i < NN; i++)
            if (i < out_log.size()) chk("t1_order", out_log[i], exp_order[i]);
        chk("t1_beats", out_log.size(), NN);
        chk("t1_tlast_count", last_log.size(), 4);
        for (int j = 0; j < 4; j++)
            if (j < last_log.size()) chk("t1_tlast_pos", last_log[j], 4 * j + 3);

        // Random stalls on both sides, three frames of random data
        rdy_pct = 50;
        base = out_cnt;
        for (int f = 0; f < 3; f++)
            for (int i = 0; i < NN; i++) send_beat($urandom, (i % NS) == NS - 1, 50);
        wait_frames(4);
        chk("t2_beats", out_cnt - base, 3 * NN);

        // tlast early on beat 2
        rdy_pct = 100;
        base = out_cnt;
        for (int i = 0; i < NN; i++) begin
            send_beat(32'(200 + i), i == 2, 100);
            if (i == 1) chk("t3_err_before", tlast_err, 0);
            if (i == 2) chk("t3_err_set", tlast_err, 1);
        end
        wait_frames(5);
        for (int k = 0; k < NN; k++)
            if (base + k < out_log.size())
                chk("t3_order", out_log[base + k], 200 + (k % NS) * NS + k / NS);
        chk("t3_err_held", tlast_err, 1);
        @(posedge clk); #1 tlast_err_clr = 1;
        @(posedge clk); #1 tlast_err_clr = 0;
        chk("t3_err_cleared", tlast_err, 0);

        // Reset after a partial frame, then a fresh frame
        for (int i = 0; i < 9; i++) send_beat($urandom, (i % NS) == NS - 1, 100);
        reset = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        base = out_cnt;
        for (int i = 0; i < NN; i++) send_beat(32'(300 + i), (i % NS) == NS - 1, 100);
        wait_frames(6);
        chk("t4_beats", out_cnt - base, NN);
        for (int k = 0; k < NN; k++)
            if (base + k < out_log.size())
                chk("t4_order", out_log[base + k], 300 + (k % NS) * NS + k / NS);

        // Reset while the output is valid mid-drain
        for (int i = 0; i < NN; i++) send_beat(32'(400 + i), (i % NS) == NS - 1, 100);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (m_tvalid) break;
        end
        chk("t5_valid_before", m_tvalid, 1);
        #2 reset = 1;
        #1 chk("t5_async_drop", m_tvalid, 0);
        @(posedge clk);
        @(posedge clk); #1 reset = 0;
        @(negedge clk); #1 chk("t5_tready_first", s_tready, 0);
        @(negedge clk); #1 chk("t5_tready_second", s_tready, 1);

        // Full-size frame: re=row, im=col
        @(posedge clk); #1 b_reset = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (b_s_tready) break;
        end
        @(posedge clk); #1;
        b_stall = 0;
        b_s_tvalid = 1;
        for (int i = 0; i < NNB; i++) begin
            b_s_tdata = {16'(i % NB), 16'(i / NB)};
            b_s_tlast = (i % NB) == NB - 1;
            @(negedge clk);
            if (!b_s_tready) b_stall++;
            @(posedge clk); #1;
        end
        b_s_tvalid = 0;
        b_mis = 0; b_k = 0; b_low = 0; b_fd = 0; b_tl = 0;
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            if (!b_s_tready) b_low++;
            if (b_m_tvalid) begin
                if (b_m_tdata != {16'(b_k / NB), 16'(b_k % NB)} ||
                    b_m_tlast != ((b_k % NB) == NB - 1)) begin
                    if (b_mis == 0)
                        $display("FAIL big_beat %0d: got %h expected %h", b_k, b_m_tdata,
                                 {16'(b_k / NB), 16'(b_k % NB)});
                    b_mis++;
                end
                if (b_m_tlast) b_tl++;
                b_k++;
            end
            if (b_frame_done) b_fd++;
            if (b_s_tready) break;
        end
        chk("big_fill_stalls", b_stall, 0);
        chk("big_mismatches", b_mis, 0);
        chk("big_beats", b_k, NNB);
        chk("big_tlast_count", b_tl, NB);
        chk("big_frame_done", b_fd, 1);
        chk("big_drain_cycles", b_low, NNB + 2);
        chk("big_tlast_err", b_tlast_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/corner_turn_axis.md
Name: corner_turn_axis

Overview:
- AXI-Stream frame transpose ("corner turn") buffer between the row-FFT core and the column-FFT core of the 2D FFT pipeline.
- Accepts one N×N frame of complex samples in row-major order from the row FFT master port.
- Replays the frame column-major into the column FFT slave port with full tvalid/tready/tlast handshaking.
- Replaces ad-hoc memory capture and fixed-count timing with a backpressure-correct single-buffer block.

Parameters:
- N, 128, points per FFT row/column; power of two, 4 to 256.
- DW, 32, sample width; [DW/2-1:0] real, [DW-1:DW/2] imaginary; passed through unmodified.
- LOG2N, $clog2(N), derived; must not be overridden.

Ports:
- clk  in  1  single design clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- s_axis_tdata  in  DW  row-major input sample.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  block can accept a beat.
- s_axis_tlast  in  1  upstream end-of-row marker.
- m_axis_tdata  out  DW  column-major output sample.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  downstream accepts beat.
- m_axis_tlast  out  1  end-of-column marker.
- frame_done  out  1  one-cycle pulse when the last output beat of a frame is accepted.
- tlast_err  out  1  sticky; s_axis_tlast disagreed with the row boundary.
- tlast_err_clr  in  1  synchronous clear of tlast_err.

Behaviour:
- Reset (asynchronous assert, released synchronously to clk):
  - state=FILL; wr_cnt=0, rd_cnt=0; output stage empty.
  - s_axis_tready=0 in the first cycle after reset release, then 1.
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, frame_done=0, tlast_err=0.
- Storage: one RAM of N*N words × DW, synchronous read with 1-cycle latency, one write port and one read port. No ping-pong; FILL and DRAIN never overlap.
- States:
  - FILL:
    - s_axis_tready=1.
    - A beat is accepted when tvalid&tready. It writes mem[wr_cnt], then wr_cnt++.
    - On the beat with wr_cnt==N*N-1: go to DRAIN and drop s_axis_tready in the following cycle.
  - DRAIN:
    - s_axis_tready=0; input beats are held upstream, not dropped.
    - Read index k=rd_cnt. RAM address = {k[LOG2N-1:0], k[2*LOG2N-1:LOG2N]} (bit-field swap, so address = row*N+col with row=k mod N, col=k/N).
    - Reads are issued only when the 2-entry output skid stage will have room.
    - m_axis_tlast=1 on beats where k mod N == N-1.
    - When the beat with k==N*N-1 is accepted: frame_done=1 for one cycle, state=FILL, wr_cnt=rd_cnt=0, s_axis_tready=1 next cycle.
- Throughput and latency:
  - With m_axis_tready held 1, the first m_axis_tvalid is 2 cycles after entering DRAIN, then one beat per cycle with no bubbles.
  - A frame drains in N*N+2 cycles.
- Handshake rules:
  - While m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata and m_axis_tlast hold stable.
  - m_axis_tvalid never deasserts without acceptance.
  - m_axis_tvalid does not depend combinationally on m_axis_tready.
  - The skid stage never overflows; no beat is lost or duplicated under arbitrary tready patterns.
- tlast check:
  - In FILL, for each accepted beat, expected = (wr_cnt mod N == N-1).
  - A mismatch sets tlast_err. The data is still written and counting is not resynchronised.
  - tlast_err_clr and a new mismatch in the same cycle leave tlast_err set.
- Boundaries:
  - Bursty s_axis_tvalid is tolerated; the counters advance only on handshake.
  - Reset mid-FILL or mid-DRAIN discards the partial frame and immediately drops m_axis_tvalid.
  - RAM contents need no reset.

Decomposition:
- Shared package fft2d_pkg:
  - DW default, N default, sample real/imag field slice constants.
  - State enum {FILL, DRAIN}.
- Sub-module corner_turn_ram: simple dual-port sync-read RAM, N*N×DW, infers block RAM.
- Address swap, counters, FSM and 2-entry skid stage stay in corner_turn_axis.

Test Plan:
- N=4, input data = index 0..15, tready=1 -> output order 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15; tlast on outputs 3,7,11,15; frame_done once; first m_axis_tvalid 2 cycles into DRAIN.
- N=4, m_axis_tready random 50% and s_axis_tvalid random 50% over 3 frames -> each frame bit-exact transposed; no drop or duplicate; data stable while stalled; s_axis_tready=0 throughout DRAIN.
- N=4, s_axis_tlast asserted on input beat 2 instead of 3 -> tlast_err=1 after that beat; output order unaffected; tlast_err_clr pulse -> 0.
- N=4, reset asserted after 9 input beats, then a fresh 16-beat frame -> output is only the new frame, transposed correctly.
- N=4, reset asserted mid-DRAIN with m_axis_tvalid=1 -> m_axis_tvalid=0 immediately (asynchronous); s_axis_tready=1 one cycle after reset release.
- N=128, 16384 input beats with re=row, im=col, tready=1 -> output beat k has re=k mod 128, im=k/128; 128 tlast pulses; drain completes in 16386 cycles.
